// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared CPU types: word, RAM status, arbiter state, poison word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    // Returned to a cache whose transfer was abandoned after too many errors
    localparam word_t c_POISON = 32'hBAD1BAD1;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Round-robin arbiter sharing one RAM port between icache and dcache.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_RETRY = 3
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      bus_err
);

    localparam int             c_RW        = $clog2(MAX_RETRY + 2);
    localparam logic [c_RW-1:0] c_RETRY_MAX = c_RW'(MAX_RETRY);
    localparam logic           c_GNT_I     = 1'b0;
    localparam logic           c_GNT_D     = 1'b1;

    arb_state_t      r_state;
    logic            r_last_gnt;
    logic [c_RW-1:0] r_retry;
    logic            r_bus_err;

    logic w_dreq;
    logic w_gnt_req;
    logic w_err;
    logic w_done;
    logic w_abandon;
    logic w_finish;

    assign w_dreq    = dREN | dWEN;
    assign w_gnt_req = (r_state == IGNT) ? iREN :
                       (r_state == DGNT) ? w_dreq : 1'b0;
    assign w_err     = (ramstate == ERROR);
    // A dropped request overrides whatever the RAM reports that cycle
    assign w_done    = w_gnt_req && (ramstate == ACCESS);
    assign w_abandon = w_gnt_req && w_err && (r_retry >= c_RETRY_MAX);
    assign w_finish  = w_done | w_abandon;
    assign bus_err   = r_bus_err;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_last_gnt <= c_GNT_I;
            r_retry    <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Every grant is entered from IDLE, so clearing here clears on entry
                    r_retry <= '0;
                    if (w_dreq && !(r_last_gnt == c_GNT_D && iREN)) begin
                        r_state <= DGNT;
                    end else if (iREN) begin
                        r_state <= IGNT;
                    end
                end
                IGNT, DGNT: begin
                    if (w_err) begin
                        r_bus_err <= 1'b1;
                    end
                    if (!w_gnt_req) begin
                        r_state <= IDLE;
                    end else if (w_finish) begin
                        r_state    <= IDLE;
                        r_last_gnt <= (r_state == DGNT) ? c_GNT_D : c_GNT_I;
                    end else if (w_err) begin
                        r_retry <= r_retry + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iwait   = ~w_finish;
                iload   = w_done ? ramload : (w_abandon ? c_POISON : '0);
            end
            DGNT: begin
                // A write takes precedence over a simultaneous read
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~w_finish;
                dload    = w_done ? ramload : (w_abandon ? c_POISON : '0);
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Directed and randomized checks of mem_arbiter against a grant model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int c_MAX_RETRY = 3;

    logic      CLK;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      iwait;
    logic      dwait;
    word_t     iload;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      bus_err;

    mem_arbiter #(.MAX_RETRY(c_MAX_RETRY)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Requests to present on the next cycle
    logic  n_iren, n_dren, n_dwen;
    word_t n_iaddr, n_daddr, n_dstore;

    // Transfer-level model: who owns the RAM, who was served last, errors so far
    int owner;      // 0 none, 1 icache, 2 dcache
    bit last_d;
    int errs;
    bit sticky;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic cyc(input ramstate_t rs, input word_t rl);
        bit    live, ok, give_up, d_wants;
        logic  e_iwait, e_dwait, e_ren, e_wen;
        word_t e_iload, e_dload, e_addr, e_store;
        @(posedge CLK);
        #1;
        iREN = n_iren; iaddr = n_iaddr;
        dREN = n_dren; dWEN = n_dwen; daddr = n_daddr; dstore = n_dstore;
        ramstate = rs; ramload = rl;
        @(negedge CLK);
        if (!nRST) begin
            owner = 0; last_d = 0; errs = 0; sticky = 0;
        end
        d_wants = dREN || dWEN;
        live    = (owner == 1 && iREN) || (owner == 2 && d_wants);
        ok      = live && rs == ACCESS;
        give_up = live && rs == ERROR && errs >= c_MAX_RETRY;
        e_iwait = !(owner == 1 && (ok || give_up));
        e_dwait = !(owner == 2 && (ok || give_up));
        e_iload = (owner == 1 && ok) ? rl : (owner == 1 && give_up) ? c_POISON : 32'h0;
        e_dload = (owner == 2 && ok) ? rl : (owner == 2 && give_up) ? c_POISON : 32'h0;
        e_ren   = (owner == 1) || (owner == 2 && dREN && !dWEN);
        e_wen   = (owner == 2 && dWEN);
        e_addr  = (owner == 1) ? iaddr : (owner == 2) ? daddr : 32'h0;
        e_store = (owner == 2) ? dstore : 32'h0;
        check("iwait", 32'(iwait), 32'(e_iwait));
        check("dwait", 32'(dwait), 32'(e_dwait));
        check("iload", iload, e_iload);
        check("dload", dload, e_dload);
        check("ramREN", 32'(ramREN), 32'(e_ren));
        check("ramWEN", 32'(ramWEN), 32'(e_wen));
        check("ramaddr", ramaddr, e_addr);
        check("ramstore", ramstore, e_store);
        check("bus_err", 32'(bus_err), 32'(sticky));
        if (nRST) begin
            if (owner != 0 && rs == ERROR) sticky = 1;
            if (owner == 0) begin
                errs = 0;
                if (d_wants && !(last_d && iREN)) owner = 2;
                else if (iREN) owner = 1;
            end else if (!live) begin
                owner = 0;
            end else if (ok || give_up) begin
                last_d = (owner == 2);
                owner  = 0;
            end else if (rs == ERROR) begin
                errs++;
            end
        end
    endtask

    task automatic do_reset();
        n_iren = 0; n_dren = 0; n_dwen = 0;
        nRST = 1'b0;
        cyc(FREE, '0);
        cyc(FREE, '0);
        nRST = 1'b1;
    endtask

    initial begin
        int seq[$];
        int r;
        nRST = 1'b0;
        iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
        n_iren = 0; n_dren = 0; n_dwen = 0; n_iaddr = '0; n_daddr = '0; n_dstore = '0;
        owner = 0; last_d = 0; errs = 0; sticky = 0;
        do_reset();

        // Instruction fetch with two BUSY cycles before the data arrives
        n_iren = 1; n_iaddr = 32'h40;
        cyc(FREE, '0);
        cyc(BUSY, '0);
        check("i_busy_wait", 32'(iwait), 32'd1);
        check("i_busy_addr", ramaddr, 32'h40);
        cyc(BUSY, '0);
        check("i_busy2_wait", 32'(iwait), 32'd1);
        cyc(ACCESS, 32'h8C220004);
        check("i_done_wait", 32'(iwait), 32'd0);
        check("i_done_load", iload, 32'h8C220004);
        n_iren = 0;
        cyc(FREE, 32'h8C220004);
        check("i_after_wait", 32'(iwait), 32'd1);
        check("i_after_load", iload, 32'h0);

        // Contention straight out of reset: dcache write first, then icache
        do_reset();
        n_iren = 1; n_dwen = 1; n_daddr = 32'h100; n_dstore = 32'hDEADBEEF;
        cyc(ACCESS, '0);
        cyc(ACCESS, 32'h11);
        check("first_d_wen", 32'(ramWEN), 32'd1);
        check("first_d_store", ramstore, 32'hDEADBEEF);
        check("first_d_dwait", 32'(dwait), 32'd0);
        cyc(ACCESS, '0);
        cyc(ACCESS, 32'h22);
        check("then_i_iwait", 32'(iwait), 32'd0);
        check("then_i_addr", ramaddr, 32'h40);

        // Both requesters held: completions must alternate starting with D
        do_reset();
        n_iren = 1; n_dren = 1; n_dwen = 0;
        for (int k = 0; k < 24 && seq.size() < 6; k++) begin
            cyc(ACCESS, $urandom);
            if (!dwait) seq.push_back(2);
            if (!iwait) seq.push_back(1);
        end
        check("alt_count", 32'(seq.size()), 32'd6);
        for (int k = 0; k < seq.size(); k++)
            check("alt_order", 32'(seq[k]), (k % 2 == 0) ? 32'd2 : 32'd1);

        // Two errors then success; then four errors abandons with poison
        do_reset();
        n_iren = 0; n_dren = 1; n_daddr = 32'h200;
        cyc(FREE, '0);
        cyc(ERROR, '0);
        cyc(ERROR, '0);
        check("err_sticky", 32'(bus_err), 32'd1);
        cyc(ACCESS, 32'h1234);
        check("err_ok_dwait", 32'(dwait), 32'd0);
        check("err_ok_dload", dload, 32'h1234);
        cyc(FREE, '0);
        for (int k = 0; k < 3; k++) begin
            cyc(ERROR, '0);
            check("retry_dwait", 32'(dwait), 32'd1);
        end
        cyc(ERROR, '0);
        check("abandon_dwait", 32'(dwait), 32'd0);
        check("abandon_dload", dload, c_POISON);
        n_dren = 0;
        cyc(FREE, '0);
        check("abandon_sticky", 32'(bus_err), 32'd1);

        // Dropped request mid-grant leaves last_gnt untouched
        do_reset();
        n_dren = 1;
        cyc(FREE, '0);
        cyc(BUSY, '0);
        n_dren = 0;
        cyc(BUSY, '0);
        check("drop_dwait", 32'(dwait), 32'd1);
        n_iren = 1; n_dren = 1;
        cyc(BUSY, '0);
        cyc(ACCESS, 32'h55);
        check("drop_then_d", 32'(dwait), 32'd0);
        check("drop_then_i", 32'(iwait), 32'd1);

        // Asynchronous reset while a dcache grant is in progress
        do_reset();
        n_iren = 0; n_dren = 1;
        cyc(FREE, '0);
        cyc(ERROR, '0);
        @(posedge CLK);
        #1 ramstate = BUSY;
        #1 nRST = 1'b0;
        #1;
        check("arst_iwait", 32'(iwait), 32'd1);
        check("arst_dwait", 32'(dwait), 32'd1);
        check("arst_bus_err", 32'(bus_err), 32'd0);
        check("arst_ramREN", 32'(ramREN), 32'd0);
        do_reset();

        // Randomized traffic with requests that persist and occasionally drop
        for (int k = 0; k < 600; k++) begin
            n_iren = n_iren ? ($urandom_range(0, 99) >= 8) : ($urandom_range(0, 99) < 30);
            if (n_dren || n_dwen) begin
                if ($urandom_range(0, 99) < 8) begin n_dren = 0; n_dwen = 0; end
            end else if ($urandom_range(0, 99) < 30) begin
                r = $urandom_range(0, 2);
                n_dren = (r != 1);
                n_dwen = (r != 0);
            end
            n_iaddr = $urandom; n_daddr = $urandom; n_dstore = $urandom;
            r = $urandom_range(0, 99);
            cyc((r < 15) ? FREE : (r < 45) ? BUSY : (r < 75) ? ACCESS : ERROR, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
